// File: rtl/s298_bist_driver_if.sv
// s298_bist_driver_if: pattern, response and status signals between the BIST driver and the s298 side.
interface s298_bist_driver_if;
  logic start;
  logic g0;
  logic g1;
  logic g2;
  logic [5:0] dut_out;
  logic busy;
  logic done;
  logic pass;
  logic [15:0] signature;
  modport master(input start, dut_out, output g0, g1, g2, busy, done, pass, signature);
  modport slave(output start, dut_out, input g0, g1, g2, busy, done, pass, signature);
endinterface

// File: rtl/s298_bist_driver.sv
// s298_bist_driver: LFSR pattern source on G0..G2 and 16-bit MISR compactor of the six s298 outputs,
// yielding one registered pass/fail per run.
module s298_bist_driver #(
  parameter int unsigned PAT_COUNT = 256,
  parameter int unsigned INIT_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input logic clk,
  input logic rst_n,
  s298_bist_driver_if.master bus
);
  localparam int unsigned MAXC = (PAT_COUNT > INIT_CYCLES) ? PAT_COUNT : INIT_CYCLES;
  localparam int unsigned CW = $clog2(MAXC + 1);
  if (PAT_COUNT < 1 || INIT_CYCLES < 1 || LFSR_SEED == 16'h0000) begin : g_bad_params
    $error("s298_bist_driver: PAT_COUNT and INIT_CYCLES must be >=1 and LFSR_SEED nonzero");
  end
  typedef enum logic [2:0] {IDLE, INIT, RUN, FLUSH, DONE} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_lfsr;
  logic [15:0] r_misr;
  logic [2:0] r_pat;
  logic r_busy;
  logic r_done;
  logic r_pass;
  logic [15:0] w_lfsr_nxt;
  logic [15:0] w_misr_nxt;
  logic w_start;
  logic w_init_last;
  logic w_run_last;
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_misr_nxt = {r_misr[14:0], r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10]} ^ {10'b0, bus.dut_out};
  assign w_init_last = r_cnt == CW'(INIT_CYCLES - 1);
  assign w_run_last = r_cnt == CW'(PAT_COUNT - 1);
  assign w_start = bus.start && (r_state == IDLE || r_state == DONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_lfsr <= LFSR_SEED;
      r_misr <= '0;
      r_pat <= 3'b001;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (w_start) begin
      r_state <= INIT;
      r_cnt <= '0;
      r_lfsr <= LFSR_SEED;
      r_misr <= '0;
      r_pat <= 3'b001;
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_cnt <= w_init_last ? '0 : r_cnt + 1'b1;
          if (w_init_last) begin
            r_state <= RUN;
            r_pat <= r_lfsr[2:0];
            r_lfsr <= w_lfsr_nxt;
          end
        end
        RUN: begin
          r_cnt <= w_run_last ? '0 : r_cnt + 1'b1;
          // the response to pattern k appears one cycle later, so the first RUN cycle has nothing to sample
          if (r_cnt != '0) r_misr <= w_misr_nxt;
          if (w_run_last) begin
            r_state <= FLUSH;
            r_pat <= 3'b001;
          end else begin
            r_pat <= r_lfsr[2:0];
            r_lfsr <= w_lfsr_nxt;
          end
        end
        FLUSH: begin
          r_misr <= w_misr_nxt;
          r_state <= DONE;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= w_misr_nxt == GOLDEN_SIG;
        end
        default: ;
      endcase
    end
  end
  assign bus.g0 = r_pat[0];
  assign bus.g1 = r_pat[1];
  assign bus.g2 = r_pat[2];
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.pass = r_pass;
  assign bus.signature = r_misr;
endmodule
